// File: rtl/qspi_target.sv
`timescale 1ns/1ps
// qspi_target: SPI-mode-0 flash-style read target, oversampled by clk.
//
// Parameters:
//   MEM_AW   - byte-address width; the address counter wraps at 2^MEM_AW
//   JEDEC_ID - three ID bytes returned by opcode 0x9F, MSB byte first
// Ports:
//   clk, rst               - system clock, synchronous active-high reset
//   sclk_i, cs_n_i, io_i   - asynchronous QSPI pads from the initiator
//   io_o, io_oe_o          - pad output values and per-lane drive enables
//   mem_req_o, mem_addr_o  - one-cycle byte read strobe and its address
//   mem_rdata_i            - read data, valid exactly one clk after mem_req_o
//   status_i               - byte returned by opcode 0x05
//   cmd_valid_o            - pulse: supported opcode received
//   err_opcode_o           - pulse: unsupported opcode received
//   opcode_o               - last received opcode
//   busy_o                 - synchronized chip select is asserted
//
// Handshake: mem_req_o is a single-cycle strobe with no back-pressure; the
// memory must present mem_rdata_i in the following clk, when it is captured.
module qspi_target #(
    parameter int          MEM_AW   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic [3:0]        io_i,
    output logic [3:0]        io_o,
    output logic [3:0]        io_oe_o,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic [7:0]        status_i,
    output logic              cmd_valid_o,
    output logic [7:0]        opcode_o,
    output logic              err_opcode_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
    state_t state;

    // Synchronizers and edge detection
    logic [1:0] sclk_sync;
    logic       sclk_d;
    logic [1:0] cs_sync;
    logic [3:0] io_s1, io_s2;
    logic [1:0] settle_cnt;
    logic       armed;

    // After reset the cs synchronizer holds a forced "deasserted" value. armed
    // only sets once the real pad value has propagated and shows cs_n high, so
    // a chip select that stayed low across reset never starts a command.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync  <= 2'b00;
            sclk_d     <= 1'b0;
            cs_sync    <= 2'b11;
            io_s1      <= 4'h0;
            io_s2      <= 4'h0;
            settle_cnt <= 2'd0;
            armed      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk_i};
            sclk_d    <= sclk_sync[1];
            cs_sync   <= {cs_sync[0], cs_n_i};
            io_s1     <= io_i;
            io_s2     <= io_s1;
            if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
            else if (cs_sync[1])    armed      <= 1'b1;
        end
    end

    logic cs_n_s, sclk_rise, sclk_fall;
    assign cs_n_s    = cs_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[1] & sclk_d;
    assign busy_o    = ~cs_n_s;

    // Datapath registers
    logic [4:0]  bit_cnt;
    logic [6:0]  cmd_sh;
    logic [22:0] addr_sh;
    logic [7:0]  out_sh;
    logic [2:0]  out_cnt;
    logic [1:0]  id_idx;
    logic        has_dummy;
    logic        cap_pending;
    logic [7:0]  pf_data;

    logic [7:0]  cmd_next;
    logic [23:0] addr_next;
    logic        is_quad, is_read;
    logic [7:0]  src_byte;

    assign cmd_next  = {cmd_sh, io_s2[0]};
    assign addr_next = {addr_sh, io_s2[0]};
    assign is_quad   = (opcode_o == 8'h6B);
    assign is_read   = (opcode_o == 8'h03) || (opcode_o == 8'h0B) || is_quad;

    always_comb begin
        src_byte = pf_data;
        if (opcode_o == 8'h9F) begin
            case (id_idx)
                2'd0:    src_byte = JEDEC_ID[23:16];
                2'd1:    src_byte = JEDEC_ID[15:8];
                2'd2:    src_byte = JEDEC_ID[7:0];
                default: src_byte = 8'h00;
            endcase
        end else if (opcode_o == 8'h05) begin
            src_byte = status_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            io_o         <= 4'h0;
            io_oe_o      <= 4'h0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            cmd_valid_o  <= 1'b0;
            err_opcode_o <= 1'b0;
            opcode_o     <= 8'h00;
            bit_cnt      <= 5'd0;
            cmd_sh       <= 7'd0;
            addr_sh      <= 23'd0;
            out_sh       <= 8'h00;
            out_cnt      <= 3'd0;
            id_idx       <= 2'd0;
            has_dummy    <= 1'b0;
            cap_pending  <= 1'b0;
            pf_data      <= 8'h00;
        end else begin
            mem_req_o    <= 1'b0;
            cmd_valid_o  <= 1'b0;
            err_opcode_o <= 1'b0;
            cap_pending  <= mem_req_o;
            if (cap_pending) pf_data <= mem_rdata_i;

            // Deasserted chip select wins over any sclk edge in the same clk.
            if (cs_n_s) begin
                state       <= IDLE;
                io_oe_o     <= 4'h0;
                io_o        <= 4'h0;
                cap_pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state   <= CMD;
                            bit_cnt <= 5'd0;
                            cmd_sh  <= 7'd0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sh  <= cmd_next[6:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                opcode_o <= cmd_next;
                                bit_cnt  <= 5'd0;
                                out_cnt  <= 3'd0;
                                id_idx   <= 2'd0;
                                case (cmd_next)
                                    8'h03: begin
                                        cmd_valid_o <= 1'b1;
                                        has_dummy   <= 1'b0;
                                        state       <= ADDR;
                                    end
                                    8'h0B, 8'h6B: begin
                                        cmd_valid_o <= 1'b1;
                                        has_dummy   <= 1'b1;
                                        state       <= ADDR;
                                    end
                                    8'h9F, 8'h05: begin
                                        cmd_valid_o <= 1'b1;
                                        state       <= DATA;
                                    end
                                    default: begin
                                        err_opcode_o <= 1'b1;
                                        state        <= IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr_sh <= addr_next[22:0];
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                mem_req_o  <= 1'b1;
                                mem_addr_o <= addr_next[MEM_AW-1:0];
                                bit_cnt    <= 5'd0;
                                state      <= has_dummy ? DUMMY : DATA;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) state <= DATA;
                        end
                    end
                    DATA: begin
                        if (sclk_fall) begin
                            if (out_cnt == 3'd0) begin
                                // Byte boundary: load the next byte, drive its
                                // first bit/nibble and prefetch the one after.
                                io_oe_o <= is_quad ? 4'b1111 : 4'b0010;
                                if (is_quad) begin
                                    io_o   <= src_byte[7:4];
                                    out_sh <= {src_byte[3:0], 4'h0};
                                end else begin
                                    io_o   <= {2'b00, src_byte[7], 1'b0};
                                    out_sh <= {src_byte[6:0], 1'b0};
                                end
                                out_cnt <= 3'd1;
                                if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                                if (is_read) begin
                                    mem_req_o  <= 1'b1;
                                    mem_addr_o <= mem_addr_o + MEM_AW'(1);
                                end
                            end else if (is_quad) begin
                                io_o    <= out_sh[7:4];
                                out_sh  <= {out_sh[3:0], 4'h0};
                                out_cnt <= 3'd0;
                            end else begin
                                io_o    <= {2'b00, out_sh[7], 1'b0};
                                out_sh  <= {out_sh[6:0], 1'b0};
                                out_cnt <= out_cnt + 3'd1;
                            end
                        end
                    end
                    default: ; // IGNORE: outputs stay off until cs_n rises
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_target.sv
`timescale 1ns/1ps
module tb_qspi_target;
  localparam int MEM_AW = 24;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              sclk_i, cs_n_i;
  logic [3:0]        io_i, io_o, io_oe_o;
  logic              mem_req_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [7:0]        mem_rdata_i, status_i, opcode_o;
  logic              cmd_valid_o, err_opcode_o, busy_o;

  qspi_target #(.MEM_AW(MEM_AW), .JEDEC_ID(24'hEF4018)) dut (
    .clk(clk), .rst(rst), .sclk_i(sclk_i), .cs_n_i(cs_n_i), .io_i(io_i),
    .io_o(io_o), .io_oe_o(io_oe_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .status_i(status_i), .cmd_valid_o(cmd_valid_o),
    .opcode_o(opcode_o), .err_opcode_o(err_opcode_o), .busy_o(busy_o)
  );

  // scoreboard state
  int n_pass = 0;
  int n_total = 0;
  int req_cnt = 0;
  int err_cnt = 0;
  int cv_cnt = 0;
  logic [23:0] addr_q[$];
  logic        pend = 1'b0;
  logic [23:0] pend_addr = 24'h0;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ (a[23:16] & 8'h5A);
  endfunction

  // memory responder (data valid only in the clk after the strobe) + monitor
  always @(negedge clk) begin
    mem_rdata_i = pend ? mem_byte(pend_addr) : 8'h5A;
    pend = (mem_req_o === 1'b1);
    pend_addr = mem_addr_o;
    if (mem_req_o === 1'b1) begin
      req_cnt++;
      addr_q.push_back(mem_addr_o);
    end
    if (err_opcode_o === 1'b1) err_cnt++;
    if (cmd_valid_o === 1'b1) cv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [23:0] q_at(input int i);
    if (addr_q.size() > i) return addr_q[i];
    return 24'hDEAD00;
  endfunction

  task automatic clear_mon();
    @(posedge clk);
    req_cnt = 0;
    err_cnt = 0;
    cv_cnt = 0;
    addr_q.delete();
  endtask

  // driver tasks (sclk period = 10 clk)
  task automatic bit_cycle(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
    @(negedge clk);
    sclk_i = 1'b0;
    io_i = din;
    repeat (4) @(negedge clk);
    dout = io_o;
    oe = io_oe_o;
    sclk_i = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_begin();
    @(negedge clk);
    sclk_i = 1'b0;
    cs_n_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    @(negedge clk);
    sclk_i = 1'b0;
    repeat (5) @(negedge clk);
    cs_n_i = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n, output logic [3:0] oe_or);
    logic [3:0] d, oe;
    oe_or = 4'h0;
    for (int i = n - 1; i >= 0; i--) begin
      bit_cycle({3'b000, v[i]}, d, oe);
      oe_or = oe_or | oe;
    end
  endtask

  task automatic recv_byte(input bit quad, output logic [7:0] b, output logic [3:0] oe_or);
    logic [3:0] d, oe;
    b = 8'h00;
    oe_or = 4'h0;
    for (int i = 0; i < (quad ? 2 : 8); i++) begin
      bit_cycle(4'h0, d, oe);
      oe_or = oe_or | oe;
      b = quad ? {b[3:0], d} : {b[6:0], d[1]};
    end
  endtask

  logic [7:0] b;
  logic [3:0] oe_pre, oe_dat, oe_t;

  initial begin
    rst = 1'b1;
    sclk_i = 1'b0;
    cs_n_i = 1'b1;
    io_i = 4'h0;
    status_i = 8'h00;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_io_o", io_o, 4'h0);
    check("rst_io_oe", io_oe_o, 4'h0);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 24'h0);
    check("rst_cmd_valid", cmd_valid_o, 1'b0);
    check("rst_err", err_opcode_o, 1'b0);
    check("rst_opcode", opcode_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // 0x03 read at 0x000010
    clear_mon();
    cs_begin();
    check("rd_busy", busy_o, 1'b1);
    send_bits(24'h03, 8, oe_t);
    oe_pre = oe_t;
    send_bits(24'h000010, 24, oe_t);
    oe_pre = oe_pre | oe_t;
    check("rd_oe_pre", oe_pre, 4'h0);
    recv_byte(1'b0, b, oe_dat); check("rd_b0", b, 8'h10);
    check("rd_oe", oe_dat, 4'b0010);
    recv_byte(1'b0, b, oe_t); check("rd_b1", b, 8'h11);
    recv_byte(1'b0, b, oe_t); check("rd_b2", b, 8'h12);
    cs_end();
    check("rd_busy_end", busy_o, 1'b0);
    check("rd_oe_end", io_oe_o, 4'h0);
    check("rd_a0", q_at(0), 24'h000010);
    check("rd_a1", q_at(1), 24'h000011);
    check("rd_a2", q_at(2), 24'h000012);
    check("rd_a3", q_at(3), 24'h000013);
    check("rd_cv", cv_cnt, 1);
    check("rd_opcode", opcode_o, 8'h03);

    // 0x6B quad read at 0xFFFFFF (wraps)
    clear_mon();
    cs_begin();
    send_bits(24'h6B, 8, oe_t);
    oe_pre = oe_t;
    send_bits(24'hFFFFFF, 24, oe_t);
    oe_pre = oe_pre | oe_t;
    send_bits(24'h0, 8, oe_t);
    oe_pre = oe_pre | oe_t;
    check("qd_oe_pre", oe_pre, 4'h0);
    recv_byte(1'b1, b, oe_dat); check("qd_b0", b, 8'hA5);
    check("qd_oe", oe_dat, 4'hF);
    recv_byte(1'b1, b, oe_t); check("qd_b1", b, 8'h00);
    recv_byte(1'b1, b, oe_t); check("qd_b2", b, 8'h01);
    cs_end();
    check("qd_a0", q_at(0), 24'hFFFFFF);
    check("qd_a1", q_at(1), 24'h000000);
    check("qd_a2", q_at(2), 24'h000001);

    // 0x9F JEDEC ID, 40 sclk cycles
    clear_mon();
    cs_begin();
    send_bits(24'h9F, 8, oe_t);
    recv_byte(1'b0, b, oe_t); check("id_b0", b, 8'hEF);
    recv_byte(1'b0, b, oe_t); check("id_b1", b, 8'h40);
    recv_byte(1'b0, b, oe_t); check("id_b2", b, 8'h18);
    recv_byte(1'b0, b, oe_t); check("id_b3", b, 8'h00);
    cs_end();
    check("id_no_req", req_cnt, 0);
    check("id_opcode", opcode_o, 8'h9F);

    // invalid opcode 0x00, then status reads
    clear_mon();
    cs_begin();
    send_bits(24'h00, 8, oe_t);
    send_bits(24'hFFFF, 16, oe_t);
    cs_end();
    check("inv_err", err_cnt, 1);
    check("inv_oe", oe_t, 4'h0);
    check("inv_no_req", req_cnt, 0);
    check("inv_no_cv", cv_cnt, 0);
    status_i = 8'hA5;
    cs_begin();
    send_bits(24'h05, 8, oe_t);
    recv_byte(1'b0, b, oe_t); check("st_b0", b, 8'hA5);
    status_i = 8'h3C;
    recv_byte(1'b0, b, oe_t); check("st_b1", b, 8'h3C);
    cs_end();

    // cs_n rise after 12 address bits, then a good 0x0B read
    clear_mon();
    cs_begin();
    send_bits(24'h0B, 8, oe_t);
    send_bits(24'h000, 12, oe_t);
    cs_end();
    check("ab_busy", busy_o, 1'b0);
    check("ab_oe", io_oe_o, 4'h0);
    check("ab_no_req", req_cnt, 0);
    check("ab_no_err", err_cnt, 0);
    clear_mon();
    cs_begin();
    send_bits(24'h0B, 8, oe_t);
    send_bits(24'h000123, 24, oe_t);
    send_bits(24'h0, 8, oe_t);
    check("fr_oe_dummy", oe_t, 4'h0);
    recv_byte(1'b0, b, oe_t); check("fr_b0", b, 8'h23);
    recv_byte(1'b0, b, oe_t); check("fr_b1", b, 8'h24);
    cs_end();
    check("fr_a0", q_at(0), 24'h000123);

    // rst pulse during DATA
    cs_begin();
    send_bits(24'h03, 8, oe_t);
    send_bits(24'h000040, 24, oe_t);
    recv_byte(1'b0, b, oe_t); check("rr_b0", b, 8'h40);
    send_bits(24'h0, 3, oe_t);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rr_oe", io_oe_o, 4'h0);
    check("rr_io", io_o, 4'h0);
    check("rr_req_addr", {7'd0, mem_req_o, mem_addr_o}, 32'h0);
    check("rr_flags", {cmd_valid_o, err_opcode_o, busy_o}, 3'b000);
    check("rr_opcode", opcode_o, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    send_bits(24'h9F, 8, oe_t);
    oe_pre = oe_t;
    send_bits(24'hFF, 8, oe_t);
    oe_pre = oe_pre | oe_t;
    check("rr_no_cv", cv_cnt + err_cnt, 0);
    check("rr_no_oe", oe_pre, 4'h0);
    cs_end();
    status_i = 8'h5C;
    cs_begin();
    send_bits(24'h05, 8, oe_t);
    recv_byte(1'b0, b, oe_t); check("rr_st", b, 8'h5C);
    cs_end();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/qspi_target.md
QSPI_TARGET -- requirements
Module: qspi_target

Interface
REQ-001 SHALL have parameter MEM_AW, default 24: byte-address width; the address counter wraps at 2^MEM_AW.
REQ-002 SHALL have parameter JEDEC_ID, default 24'hEF4018: three bytes returned by opcode 0x9F, MSB byte first.
REQ-003 SHALL have port clk, input, 1: the single system clock; every flop uses its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sclk_i, input, 1: QSPI serial clock from the initiator, asynchronous to clk.
REQ-006 SHALL have port cs_n_i, input, 1: chip select, active low, asynchronous.
REQ-007 SHALL have port io_i, input, 4: pad input values of io0..io3.
REQ-008 SHALL have port io_o, output, 4: pad output values.
REQ-009 SHALL have port io_oe_o, output, 4: per-lane output enable, 1 = drive.
REQ-010 SHALL have port mem_req_o, output, 1: one-cycle byte read strobe.
REQ-011 SHALL have port mem_addr_o, output, MEM_AW: byte address, valid while mem_req_o=1.
REQ-012 SHALL have port mem_rdata_i, input, 8: byte data, valid exactly 1 clk after mem_req_o.
REQ-013 SHALL have port status_i, input, 8: byte returned by opcode 0x05.
REQ-014 SHALL have port cmd_valid_o, output, 1: one-cycle pulse when a supported opcode has been received.
REQ-015 SHALL have port opcode_o, output, 8: last received opcode; holds until the next opcode.
REQ-016 SHALL have port err_opcode_o, output, 1: one-cycle pulse when an unsupported opcode has been received.
REQ-017 SHALL have port busy_o, output, 1: high while the synchronized cs_n is low.

Function
REQ-018 SHALL pass sclk_i, cs_n_i and io_i each through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-019 SHALL detect sclk rise and fall as one-clk pulses from the synchronized value and its 1-clk delayed copy.
REQ-020 SHALL support only SPI mode 0: sample inputs on the detected rise; update outputs on the detected fall.
REQ-021 SHALL operate correctly for sclk period >= 8 clk periods; behaviour at faster sclk is undefined.
REQ-022 SHALL have states IDLE, CMD, ADDR, DUMMY, DATA, IGNORE; the state is IDLE whenever the synchronized cs_n = 1.
REQ-023 SHALL transition IDLE->CMD on the cs_n falling edge, clearing the bit counter and shift register.
REQ-024 In CMD, SHALL shift io0 MSB-first for 8 rises; on the 8th rise, SHALL latch opcode_o and branch as listed below.
REQ-025 Opcode 0x03 (read, 1-1-1): ADDR, 0 dummy cycles, single-lane data on io1.
REQ-026 Opcode 0x0B (fast read, 1-1-1): ADDR, 8 dummy cycles, single-lane data on io1.
REQ-027 Opcode 0x6B (quad output read, 1-1-4): ADDR, 8 dummy cycles, data on io3..io0 with the high nibble first and io3 = MSB.
REQ-028 Opcodes 0x9F and 0x05: go directly to DATA, single lane; no address, no dummy cycles.
REQ-029 Any other opcode: go to IGNORE and pulse err_opcode_o; io_oe_o stays 0 until cs_n rises; mem_req_o is never issued.
REQ-030 ADDR SHALL shift 24 bits on io0, MSB-first, and keep the low MEM_AW bits.
REQ-031 On the 24th address rise, SHALL pulse mem_req_o with that address, then go to DUMMY, or to DATA if the dummy count is 0.
REQ-032 DUMMY SHALL count sclk rises; io_oe_o stays 0 throughout.
REQ-033 DATA byte-source rules:
- 0x9F: JEDEC_ID bytes, then 0x00 forever.
- 0x05: status_i resampled at each byte boundary, repeating.
- Read opcodes: the prefetched mem_rdata_i, captured 1 clk after mem_req_o.
REQ-034 Memory reads SHALL be pipelined: after loading byte N into the output shifter, the block SHALL increment the address modulo 2^MEM_AW and pulse mem_req_o for byte N+1.
REQ-035 Output enables SHALL assert on the first sclk fall in DATA, with io1 already holding the first bit: io_oe_o = 4'b0010 for single lane, 4'b1111 for quad.
REQ-036 DATA SHALL continue with no length limit until cs_n rises.
REQ-037 cs_n rise in any state SHALL, within 1 clk of the synchronized edge:
- go to IDLE;
- set io_oe_o = 0;
- cancel pending mem reads (drop a capture in flight);
- produce no error.
REQ-038 An sclk edge in the same clk as a cs_n rise SHALL be ignored.
REQ-039 cmd_valid_o and err_opcode_o SHALL pulse in the same clk as the 8th CMD rise.

Reset
REQ-040 With rst=1, SHALL hold all outputs at these values: io_o=0, io_oe_o=0, mem_req_o=0, mem_addr_o=0, cmd_valid_o=0, err_opcode_o=0, opcode_o=0, busy_o=0.
REQ-041 rst=1 SHALL load all synchronizers with idle values: sclk=0, cs_n=1, io=0.
REQ-042 rst asserted mid-transfer SHALL abort immediately; after rst is released, the block SHALL wait in IDLE for a fresh cs_n fall before decoding.

Verification
REQ-043 Case 0x03 read:
- Stimulus: addr 0x000010; memory returns addr[7:0].
- Response: io1 serializes 0x10, 0x11, 0x12; mem_addr_o = 0x10, 0x11, 0x12, 0x13.
REQ-044 Case 0x6B quad read:
- Stimulus: addr 0xFFFFFF, 8 dummy cycles.
- Response: io_oe_o = 4'hF; nibbles for mem[0xFFFFFF] then mem[0x000000] (address wraps).
REQ-045 Case 0x9F ID read:
- Stimulus: 40 sclk cycles.
- Response: bytes 0xEF, 0x40, 0x18, 0x00; no mem_req_o.
REQ-046 Case invalid opcode 0x00:
- Response: err_opcode_o pulses once, io_oe_o = 0, no mem_req_o.
- Follow-up: a 0x05 transfer with status_i = 0xA5 then returns 0xA5.
REQ-047 Case cs_n rise after 12 address bits:
- Response: IDLE within 3 clk, no mem_req_o; the next 0x0B transfer reads correctly.
REQ-048 Case rst pulse during DATA:
- Response: io_oe_o = 0 the next clk; all outputs at reset values.
